am25ls2548_ws: RTL and testbench

Clocked, parametrised successor to the Am25LS2548 chip-select decoder. Decodes a SELW-bit address into 2**SELW active-low selects that are asserted only during an enabled RD_/WR_ strobe. Each channel has its own wait-state count, loaded at run time, and the block delays ACK_ by that many cycles. It sits between the microprogrammed bus sequencer and slow peripherals, replacing the combinational decoder plus external wait-state logic.

---
 rtl/am25ls2548_ws_pkg.sv | 24 ++
 rtl/am25ls2548_ws_if.sv | 30 +++
 rtl/am25ls2548_wsreg.sv | 31 +++
 rtl/am25ls2548_ws.sv | 98 +++++++++
 tb/tb_am25ls2548_ws.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/am25ls2548_ws_pkg.sv
// Shared types and helpers for the am25ls2548_ws chip-select decoder with wait states.
// Holds the FSM state encodings and the enable/strobe qualifiers used by the top level.
package am25ls2548_ws_pkg;

  localparam int DEF_SELW  = 3;
  localparam int DEF_WSW   = 2;
  localparam int DEF_WSRST = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  function automatic logic bus_en(input logic e1_, input logic e2_, input logic e3, input logic e4);
    return !e1_ && !e2_ && e3 && e4;
  endfunction

  // Both strobes low together behave as one strobe.
  function automatic logic bus_strb(input logic rd_, input logic wr_);
    return !rd_ || !wr_;
  endfunction

endpackage

// File: rtl/am25ls2548_ws_if.sv
// Bus between the microprogrammed sequencer (master) and the chip-select decoder (slave).
interface am25ls2548_ws_if
  import am25ls2548_ws_pkg::*;
  #(parameter int SELW = DEF_SELW,
    parameter int WSW  = DEF_WSW);

  logic [SELW-1:0]       a;
  logic                  e1_;
  logic                  e2_;
  logic                  e3;
  logic                  e4;
  logic                  rd_;
  logic                  wr_;
  logic                  ld_;
  logic [WSW-1:0]        wsin;
  logic [(1<<SELW)-1:0]  y_;
  logic                  ack_;
  logic                  busy;

  modport master (
    output a, e1_, e2_, e3, e4, rd_, wr_, ld_, wsin,
    input  y_, ack_, busy
  );

  modport slave (
    input  a, e1_, e2_, e3, e4, rd_, wr_, ld_, wsin,
    output y_, ack_, busy
  );

endinterface

// File: rtl/am25ls2548_wsreg.sv
// Per-channel wait-state register file: one synchronous write port, one combinational read port.
module am25ls2548_wsreg
  import am25ls2548_ws_pkg::*;
  #(parameter int SELW  = DEF_SELW,
    parameter int WSW   = DEF_WSW,
    parameter int WSRST = DEF_WSRST)
  (
    input  logic            clk,
    input  logic            rst_,
    input  logic            we,
    input  logic [SELW-1:0] waddr,
    input  logic [WSW-1:0]  wdata,
    input  logic [SELW-1:0] raddr,
    output logic [WSW-1:0]  rdata
  );

  localparam int NCH = 1 << SELW;

  logic [WSW-1:0] mem [NCH];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < NCH; i++) mem[i] <= WSW'(WSRST);
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/am25ls2548_ws.sv
// Clocked chip-select decoder: one active-low select per channel during an enabled strobe,
// with ack_ delayed by a run-time loadable per-channel wait-state count.
module am25ls2548_ws
  import am25ls2548_ws_pkg::*;
  #(parameter int SELW  = DEF_SELW,
    parameter int WSW   = DEF_WSW,
    parameter int WSRST = DEF_WSRST)
  (
    input  logic            clk,
    input  logic            rst_,
    am25ls2548_ws_if.slave  bus
  );

  localparam int NCH = 1 << SELW;

  state_t          state, nxt_state;
  logic [SELW-1:0] sel, nxt_sel;
  logic [WSW-1:0]  cnt, nxt_cnt;
  logic            strb_prev;
  logic [NCH-1:0]  y_q, nxt_y;
  logic            ack_q, nxt_ack;
  logic            busy_q, nxt_busy;
  logic [WSW-1:0]  rdata;
  logic            we;
  logic            en;
  logic            strb;

  assign en   = bus_en(bus.e1_, bus.e2_, bus.e3, bus.e4);
  assign strb = bus_strb(bus.rd_, bus.wr_);

  am25ls2548_wsreg #(.SELW(SELW), .WSW(WSW), .WSRST(WSRST)) u_wsreg (
    .clk   (clk),
    .rst_  (rst_),
    .we    (we),
    .waddr (bus.a),
    .wdata (bus.wsin),
    .raddr (bus.a),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      sel       <= '0;
      cnt       <= '0;
      strb_prev <= 1'b1;
      y_q       <= '1;
      ack_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state     <= nxt_state;
      sel       <= nxt_sel;
      cnt       <= nxt_cnt;
      strb_prev <= strb;
      y_q       <= nxt_y;
      ack_q     <= nxt_ack;
      busy_q    <= nxt_busy;
    end
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    nxt_state = state;
    nxt_sel   = sel;
    nxt_cnt   = cnt;
    we        = 1'b0;
    case (state)
      IDLE: begin
        if (en && strb && !strb_prev) begin
          nxt_sel   = bus.a;
          nxt_cnt   = rdata;
          nxt_state = (rdata != '0) ? WAIT : ACK;
        end else if (en && !strb && !bus.ld_) begin
          we = 1'b1;
        end
      end
      WAIT: begin
        if (!(en && strb)) nxt_state = IDLE;
        else if (cnt > WSW'(1)) nxt_cnt = cnt - WSW'(1);
        else nxt_state = ACK;
      end
      ACK: begin
        if (!(en && strb)) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase

    nxt_y = '1;
    if (nxt_state != IDLE) nxt_y[nxt_sel] = 1'b0;
    nxt_ack  = (nxt_state != ACK);
    nxt_busy = (nxt_state != IDLE);
  end

  assign bus.y_   = y_q;
  assign bus.ack_ = ack_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_am25ls2548_ws.sv
// Scoreboard bench for am25ls2548_ws: each driven cycle pushes the outputs expected after its edge.
module tb_am25ls2548_ws;

  localparam logic [3:0] EN  = 4'b0011;  // {e1_, e2_, e3, e4} all active
  localparam logic [7:0] YID = 8'hFF;

  typedef struct {
    string      tag;
    logic [7:0] y;
    logic       ack;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst_;
  int   testCount;
  int   failCount;
  exp_t sbq[$];

  am25ls2548_ws_if #(.SELW(3), .WSW(2)) bus ();

  am25ls2548_ws #(.SELW(3), .WSW(2), .WSRST(0)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sel_n(input int k);
    logic [7:0] v;
    v = 8'hFF;
    v[k] = 1'b0;
    return v;
  endfunction

  // Drive one cycle's inputs, record what must be visible after the coming edge.
  task automatic applyStimulus(input string tag, input logic [2:0] ai, input logic [3:0] en4,
                               input logic rdi, input logic wri, input logic ldi,
                               input logic [1:0] wsi, input logic [7:0] ey,
                               input logic eack, input logic ebusy);
    exp_t e;
    bus.a    = ai;
    bus.e1_  = en4[3];
    bus.e2_  = en4[2];
    bus.e3   = en4[1];
    bus.e4   = en4[0];
    bus.rd_  = rdi;
    bus.wr_  = wri;
    bus.ld_  = ldi;
    bus.wsin = wsi;
    e.tag = tag; e.y = ey; e.ack = eack; e.busy = ebusy;
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      checkOutput({e.tag, ".y_"},   bus.y_, e.y);
      checkOutput({e.tag, ".ack_"}, {7'd0, bus.ack_}, {7'd0, e.ack});
      checkOutput({e.tag, ".busy"}, {7'd0, bus.busy}, {7'd0, e.busy});
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    testCount = 0;
    failCount = 0;
    rst_ = 1'b1;
    bus.a = '0; bus.e1_ = 1'b0; bus.e2_ = 1'b0; bus.e3 = 1'b1; bus.e4 = 1'b1;
    bus.rd_ = 1'b1; bus.wr_ = 1'b1; bus.ld_ = 1'b1; bus.wsin = '0;
    #2 rst_ = 1'b0;
    #10;
    checkOutput("rst.y_",   bus.y_, YID);
    checkOutput("rst.ack_", {7'd0, bus.ack_}, 8'd1);
    checkOutput("rst.busy", {7'd0, bus.busy}, 8'd0);
    #1 rst_ = 1'b1;

    applyStimulus("idle",      3'd0, EN,      1, 1, 1, 2'd0, YID, 1, 0);
    // Enables inactive: strobe alone selects nothing.
    applyStimulus("dis_e3",    3'd0, 4'b0001, 0, 1, 1, 2'd0, YID, 1, 0);
    applyStimulus("dis_e1",    3'd0, 4'b1011, 0, 1, 1, 2'd0, YID, 1, 0);
    applyStimulus("rel0",      3'd0, EN,      1, 1, 1, 2'd0, YID, 1, 0);
    applyStimulus("zw_e0",     3'd0, EN,      0, 1, 1, 2'd0, 8'hFE, 0, 1);
    applyStimulus("zw_hold",   3'd0, EN,      0, 1, 1, 2'd0, 8'hFE, 0, 1);
    applyStimulus("zw_rel",    3'd0, EN,      1, 1, 1, 2'd0, YID, 1, 0);

    // Two wait states on channel 5, address changed mid-wait.
    applyStimulus("ld5",       3'd5, EN,      1, 1, 0, 2'd2, YID, 1, 0);
    applyStimulus("ws5_e0",    3'd5, EN,      1, 0, 1, 2'd0, 8'hDF, 1, 1);
    applyStimulus("ws5_e1",    3'd1, EN,      1, 0, 1, 2'd0, 8'hDF, 1, 1);
    applyStimulus("ws5_e2",    3'd1, EN,      1, 0, 1, 2'd0, 8'hDF, 0, 1);
    applyStimulus("ws5_hold",  3'd1, EN,      1, 0, 1, 2'd0, 8'hDF, 0, 1);
    applyStimulus("ws5_rel",   3'd1, EN,      1, 1, 1, 2'd0, YID, 1, 0);

    // Abort during wait: no ack ever.
    applyStimulus("ld3",       3'd3, EN,      1, 1, 0, 2'd3, YID, 1, 0);
    applyStimulus("ab_e0",     3'd3, EN,      0, 1, 1, 2'd0, sel_n(3), 1, 1);
    applyStimulus("ab_rel",    3'd3, EN,      1, 1, 1, 2'd0, YID, 1, 0);
    applyStimulus("ab_idle",   3'd3, EN,      1, 1, 1, 2'd0, YID, 1, 0);

    // Held strobe across an enable drop must not restart a cycle.
    applyStimulus("hs_e0",     3'd0, EN,      0, 1, 1, 2'd0, 8'hFE, 0, 1);
    applyStimulus("hs_drop",   3'd0, 4'b0001, 0, 1, 1, 2'd0, YID, 1, 0);
    applyStimulus("hs_back",   3'd0, EN,      0, 1, 1, 2'd0, YID, 1, 0);
    applyStimulus("hs_back2",  3'd0, EN,      0, 1, 1, 2'd0, YID, 1, 0);
    applyStimulus("hs_high",   3'd0, EN,      1, 1, 1, 2'd0, YID, 1, 0);
    applyStimulus("hs_new",    3'd0, EN,      0, 1, 1, 2'd0, 8'hFE, 0, 1);
    applyStimulus("hs_rel",    3'd0, EN,      1, 1, 1, 2'd0, YID, 1, 0);

    // Load together with strobe: the strobe wins, ws[4] keeps 0.
    applyStimulus("lvs_e0",    3'd4, EN,      0, 1, 0, 2'd3, sel_n(4), 0, 1);
    applyStimulus("lvs_rel",   3'd4, EN,      1, 1, 1, 2'd0, YID, 1, 0);
    applyStimulus("lvs_chk",   3'd4, EN,      0, 0, 1, 2'd0, sel_n(4), 0, 1);
    applyStimulus("lvs_rel2",  3'd4, EN,      1, 1, 1, 2'd0, YID, 1, 0);

    // Asynchronous reset in the middle of a wait.
    applyStimulus("ld2",       3'd2, EN,      1, 1, 0, 2'd3, YID, 1, 0);
    applyStimulus("mr_e0",     3'd2, EN,      0, 1, 1, 2'd0, 8'hFB, 1, 1);
    applyStimulus("mr_e1",     3'd2, EN,      0, 1, 1, 2'd0, 8'hFB, 1, 1);
    rst_ = 1'b0;
    #1;
    checkOutput("mrst.y_",   bus.y_, YID);
    checkOutput("mrst.ack_", {7'd0, bus.ack_}, 8'd1);
    checkOutput("mrst.busy", {7'd0, bus.busy}, 8'd0);
    #1 rst_ = 1'b1;
    applyStimulus("mr_held",   3'd2, EN,      0, 1, 1, 2'd0, YID, 1, 0);
    applyStimulus("mr_high",   3'd2, EN,      1, 1, 1, 2'd0, YID, 1, 0);
    applyStimulus("mr_zw",     3'd2, EN,      0, 1, 1, 2'd0, 8'hFB, 0, 1);
    applyStimulus("mr_rel",    3'd2, EN,      1, 1, 1, 2'd0, YID, 1, 0);

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
    #2;
    checkOutput("sb_drain", 8'(sbq.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
